twpm_ram_arbiter: RTL and testbench
===================================

# twpm_ram_arbiter

Single-clock arbiter that shares the TPM command/response buffer RAM (512x32, synchronous, byte write enables) between the CPU Wishbone slave port and the byte-wide data-provider (DP) port of the LPC register block. It sits between the RAM instance and both requesters and replaces the per-side RAM clock multiplexing. All RAM traffic runs on `clk_i`. Access rights follow the `exec` handshake flag: the host side owns the buffer while `exec=0`, the CPU owns it while `exec=1`.

## Interface
Parameters:
- `RAM_ADDR_WIDTH`, 11: byte address width of the buffer; word address width is `RAM_ADDR_WIDTH-2`.
- `DP_ERR_DATA`, 8'hFF: read data returned to a rejected DP read.

Ports:
- `clk_i`  in  1  system/Wishbone clock; single clock domain.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `exec`  in  1  ownership flag, synchronous to `clk_i`; 1 = CPU owns buffer.
- `wb_cyc`, `wb_stb`, `wb_we`  in  1 each  Wishbone classic request qualifiers, already decoded to the RAM window.
- `wb_adr`  in  RAM_ADDR_WIDTH-2  word address.
- `wb_sel`  in  4  byte enables.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data, valid while `wb_ack`.
- `wb_ack`  out  1  transfer acknowledge.
- `wb_err`  out  1  transfer rejected.
- `dp_req`  in  1  DP request; level, held until `dp_ack`.
- `dp_we`  in  1  DP write when 1.
- `dp_addr`  in  RAM_ADDR_WIDTH  byte address.
- `dp_wdata`  in  8  write byte.
- `dp_rdata`  out  8  read byte, valid while `dp_ack`.
- `dp_ack`  out  1  DP acknowledge.
- `dp_err`  out  1  DP access rejected, qualified by `dp_ack`.
- `ram_a`  out  RAM_ADDR_WIDTH-2  RAM word address.
- `ram_wd`  out  32  RAM write data.
- `ram_wen`  out  4  RAM byte write enables, active-high.
- `ram_rd`  in  32  RAM read data, valid the cycle after address capture.

## Operation
- FSM states are IDLE, ACC and RSP. The reset state is IDLE.
- IDLE: evaluate `wb_req = wb_cyc & wb_stb` and `dp_req`. Register the grant, `ram_a`, `ram_wd` and `ram_wen`, then go to ACC. With no request, stay in IDLE.
- Arbitration: round-robin on a `last_wb` flag.
  - When both request, grant the side not served last.
  - When only one requests, grant it.
  - `last_wb` updates on every grant. Its reset value is 0, so WB wins the first tie.
- Eligibility is sampled at grant only:
  - WB write with `exec=0`: rejected.
  - DP write or DP read with `exec=1`: rejected.
  - WB reads are always eligible, for polling.
  - Rejected accesses still go through ACC and RSP, with `ram_wen=0` and an error response.
- DP lane mapping:
  - `ram_a = dp_addr[RAM_ADDR_WIDTH-1:2]`.
  - `ram_wd` = `dp_wdata` replicated in all 4 lanes.
  - `ram_wen` = one-hot of `dp_addr[1:0]`, with lane 0 = bits 7:0 (little-endian).
  - `dp_rdata` = byte `dp_addr[1:0]` of `ram_rd`, using the lane captured at grant.
- WB mapping: `ram_a = wb_adr`, `ram_wd = wb_dat_i`, `ram_wen = wb_sel` on eligible writes.
- ACC: RAM captures the registered address and data; `ram_wen` is non-zero only in this state. Go to RSP.
- RSP: pulse `ack` or `err` for one cycle on the granted side, drive read data from `ram_rd`, then go to IDLE.
  - Rejected DP read returns `DP_ERR_DATA`.
  - Rejected WB access returns 32'h0.
- WB abort (`wb_cyc` low in ACC or RSP): the RAM cycle completes; `wb_ack`/`wb_err` is suppressed.
- `exec` toggling during ACC or RSP does not affect the access in flight.

## Timing
- Reset values: FSM=IDLE, `last_wb=0`, `ram_wen=0`, `ram_a=0`, `ram_wd=0`, `wb_ack=0`, `wb_err=0`, `dp_ack=0`, `dp_err=0`, `wb_dat_o=0`, `dp_rdata=0`.
- Latency: request sampled high at edge k; ACC is cycle k+1; ack/err is high in cycle k+2 only.
- Throughput: one access per 3 cycles. A back-to-back same-side request is re-evaluated in IDLE (cycle k+3).
- The requester must deassert its request, or present the next transfer, in the cycle after ack. A request still high in IDLE is treated as a new access.
- `wb_ack` and `wb_err` are never high together, and never high outside RSP. The same holds for `dp_ack` and `dp_err`.
- Reset mid-ACC: `ram_wen` drops asynchronously and no ack is issued. A partial write is tolerated.

## Test plan
- DP write then read, `exec=0`: write 8'hA5 at byte address 11'h006, then read it back. Required: `ram_wen=4'b0100` and `ram_a=9'h001` in ACC; read returns 8'hA5 with `dp_ack` in cycle k+2.
- WB write with `exec=1`: write 32'hDEADBEEF at word 9'h010 with `sel=4'b0011`. Required: RAM word becomes 32'hxxxxBEEF; a WB read returns those low bytes; `wb_err=0`.
- Rejections:
  - WB write with `exec=0` gives `wb_err`, and the RAM is unchanged.
  - DP read with `exec=1` gives `dp_ack` + `dp_err` with `dp_rdata=8'hFF`.
- Simultaneous requests held for 4 grants: grant order is WB, DP, WB, DP; each ack lands exactly 2 cycles after its grant.
- Abort and exec change:
  - `wb_cyc` dropped in ACC gives no `wb_ack`, and the FSM returns to IDLE.
  - `exec` flipped during ACC still completes the in-flight access with its original eligibility.
- Async reset asserted in ACC of a write: all outputs hold their reset values immediately; after release, the FSM is in IDLE and the first tie goes to WB.

Source files
------------

// File: rtl/twpm_ram_arbiter_if.sv
// Bus bundle between the buffer-RAM arbiter, its two requesters (Wishbone and
// LPC data provider) and the 512x32 buffer RAM.
interface twpm_ram_arbiter_if #(
    parameter int RAM_ADDR_WIDTH = 11
);
    logic                        wb_cyc;
    logic                        wb_stb;
    logic                        wb_we;
    logic [RAM_ADDR_WIDTH-3:0]   wb_adr;
    logic [3:0]                  wb_sel;
    logic [31:0]                 wb_dat_i;
    logic [31:0]                 wb_dat_o;
    logic                        wb_ack;
    logic                        wb_err;

    logic                        dp_req;
    logic                        dp_we;
    logic [RAM_ADDR_WIDTH-1:0]   dp_addr;
    logic [7:0]                  dp_wdata;
    logic [7:0]                  dp_rdata;
    logic                        dp_ack;
    logic                        dp_err;

    logic [RAM_ADDR_WIDTH-3:0]   ram_a;
    logic [31:0]                 ram_wd;
    logic [3:0]                  ram_wen;
    logic [31:0]                 ram_rd;

    // arbiter side
    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_i,
        output wb_dat_o, wb_ack, wb_err,
        input  dp_req, dp_we, dp_addr, dp_wdata,
        output dp_rdata, dp_ack, dp_err,
        output ram_a, ram_wd, ram_wen,
        input  ram_rd
    );

    // requesters and RAM side
    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_i,
        input  wb_dat_o, wb_ack, wb_err,
        output dp_req, dp_we, dp_addr, dp_wdata,
        input  dp_rdata, dp_ack, dp_err,
        input  ram_a, ram_wd, ram_wen,
        output ram_rd
    );
endinterface

// File: rtl/twpm_ram_arbiter.sv
// Shares the TPM command/response buffer RAM between the CPU Wishbone port and
// the byte-wide LPC data provider; ownership follows the exec handshake flag.
//
//   state | meaning
//   IDLE  | arbitrate, register grant, address, data and byte enables
//   ACC   | RAM captures address/data; only state with ram_wen non-zero
//   RSP   | ack/err pulse on the granted side, read data from ram_rd
module twpm_ram_arbiter #(
    parameter int          RAM_ADDR_WIDTH = 11,
    parameter logic [7:0]  DP_ERR_DATA    = 8'hFF
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 exec,
    twpm_ram_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        last_wb;
    logic        gnt_wb;
    logic        rej;
    logic        abort;
    logic [1:0]  lane;

    logic        wb_req;
    logic        pick_wb;
    logic        pick_rej;
    logic [3:0]  dp_lane_oh;
    logic [3:0]  wen_grant;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wb_req || bus.dp_req) state_nxt = ACC;
            ACC:     state_nxt = RSP;
            RSP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Round-robin: on a tie the side not served last wins. Eligibility is
    // frozen here so an exec change mid-access cannot alter it.
    always_comb begin
        wb_req     = bus.wb_cyc & bus.wb_stb;
        pick_wb    = wb_req & (~bus.dp_req | ~last_wb);
        pick_rej   = pick_wb ? (bus.wb_we & ~exec) : exec;
        dp_lane_oh = 4'b0001 << bus.dp_addr[1:0];
        wen_grant  = 4'b0000;
        if (!pick_rej) begin
            if (pick_wb && bus.wb_we) begin
                wen_grant = bus.wb_sel;
            end else if (!pick_wb && bus.dp_we) begin
                wen_grant = dp_lane_oh;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_wb     <= 1'b0;
            gnt_wb      <= 1'b0;
            rej         <= 1'b0;
            abort       <= 1'b0;
            lane        <= 2'd0;
            bus.ram_a   <= '0;
            bus.ram_wd  <= '0;
            bus.ram_wen <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nxt == ACC) begin
                        last_wb     <= pick_wb;
                        gnt_wb      <= pick_wb;
                        rej         <= pick_rej;
                        abort       <= 1'b0;
                        lane        <= bus.dp_addr[1:0];
                        bus.ram_a   <= pick_wb ? bus.wb_adr
                                               : bus.dp_addr[RAM_ADDR_WIDTH-1:2];
                        bus.ram_wd  <= pick_wb ? bus.wb_dat_i : {4{bus.dp_wdata}};
                        bus.ram_wen <= wen_grant;
                    end
                end
                ACC: begin
                    bus.ram_wen <= 4'b0000;
                    if (gnt_wb && !bus.wb_cyc) abort <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A dropped wb_cyc in ACC or RSP lets the RAM cycle finish but silences
    // the Wishbone response.
    always_comb begin
        bus.wb_ack   = 1'b0;
        bus.wb_err   = 1'b0;
        bus.wb_dat_o = 32'h0;
        bus.dp_ack   = 1'b0;
        bus.dp_err   = 1'b0;
        bus.dp_rdata = 8'h00;
        if (state == RSP) begin
            if (gnt_wb) begin
                if (!abort && bus.wb_cyc) begin
                    if (rej) begin
                        bus.wb_err = 1'b1;
                    end else begin
                        bus.wb_ack   = 1'b1;
                        bus.wb_dat_o = bus.ram_rd;
                    end
                end
            end else begin
                bus.dp_ack = 1'b1;
                if (rej) begin
                    bus.dp_err   = 1'b1;
                    bus.dp_rdata = DP_ERR_DATA;
                end else begin
                    bus.dp_rdata = bus.ram_rd[{lane, 3'b000} +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_twpm_ram_arbiter.sv
// Directed bench for twpm_ram_arbiter: a RAM model, expected responses queued
// per side at issue time and checked by a separate monitor.
module tb_twpm_ram_arbiter;
    typedef struct {
        bit          err;
        bit          chk;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn_i;
    logic exec;
    int   cyc_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t wb_q[$];
    exp_t dp_q[$];

    twpm_ram_arbiter_if #(.RAM_ADDR_WIDTH(11)) bus ();

    twpm_ram_arbiter #(.RAM_ADDR_WIDTH(11), .DP_ERR_DATA(8'hFF)) dut (
        .clk_i  (clk),
        .rstn_i (rstn_i),
        .exec   (exec),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic [31:0] mem [0:511];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
            mem_init <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_wen[b]) mem[bus.ram_a][8*b +: 8] <= bus.ram_wd[8*b +: 8];
            bus.ram_rd <= mem[bus.ram_a];
        end
    end

    always @(negedge clk) begin
        if (bus.wb_ack || bus.wb_err) begin
            checks++;
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: ack=%0b err=%0b at cycle %0d, none expected",
                         bus.wb_ack, bus.wb_err, cyc_cnt);
            end else begin
                exp_t e;
                e = wb_q.pop_front();
                if (bus.wb_err !== e.err || bus.wb_ack !== !e.err ||
                    (e.chk && bus.wb_dat_o !== e.data) || cyc_cnt != e.cyc) begin
                    errors++;
                    $display("FAIL wb_rsp: ack=%0b err=%0b dat=%h cyc=%0d, required ack=%0b err=%0b dat=%h cyc=%0d",
                             bus.wb_ack, bus.wb_err, bus.wb_dat_o, cyc_cnt,
                             !e.err, e.err, e.data, e.cyc);
                end
            end
        end
        if (bus.dp_ack || bus.dp_err) begin
            checks++;
            if (dp_q.size() == 0) begin
                errors++;
                $display("FAIL dp_unexpected: ack=%0b err=%0b at cycle %0d, none expected",
                         bus.dp_ack, bus.dp_err, cyc_cnt);
            end else begin
                exp_t e;
                e = dp_q.pop_front();
                if (bus.dp_ack !== 1'b1 || bus.dp_err !== e.err ||
                    (e.chk && bus.dp_rdata !== e.data[7:0]) || cyc_cnt != e.cyc) begin
                    errors++;
                    $display("FAIL dp_rsp: ack=%0b err=%0b dat=%h cyc=%0d, required ack=1 err=%0b dat=%h cyc=%0d",
                             bus.dp_ack, bus.dp_err, bus.dp_rdata, cyc_cnt,
                             e.err, e.data[7:0], e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input bit is_wb, input bit err, input bit chk,
                        input logic [31:0] data, input int cyc);
        exp_t e;
        e.err = err; e.chk = chk; e.data = data; e.cyc = cyc;
        if (is_wb) wb_q.push_back(e);
        else       dp_q.push_back(e);
    endtask

    task automatic drop_all();
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        bus.dp_req = 1'b0; bus.dp_we = 1'b0;
    endtask

    task automatic issue_wb(input logic we, input logic [8:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = we;
        bus.wb_adr = adr; bus.wb_sel = sel; bus.wb_dat_i = dat;
    endtask

    task automatic issue_dp(input logic we, input logic [10:0] addr, input logic [7:0] dat);
        bus.dp_req = 1'b1; bus.dp_we = we; bus.dp_addr = addr; bus.dp_wdata = dat;
    endtask

    // waits (bounded) for any response, then drops requests once back in IDLE
    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(posedge clk); #1;
            if (bus.wb_ack || bus.wb_err || bus.dp_ack || bus.dp_err) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no response within 8 cycles, required one", name);
        end
        @(posedge clk); #1;
        drop_all();
    endtask

    task automatic tie(input int grants, input logic [8:0] wadr, input logic [31:0] wexp,
                       input logic [10:0] daddr, input logic [7:0] dexp);
        int n0;
        n0 = cyc_cnt;
        issue_wb(1'b0, wadr, 4'hF, 32'h0);
        issue_dp(1'b0, daddr, 8'h00);
        for (int g = 0; g < grants; g++) begin
            if (g % 2 == 0) push(1'b1, 1'b0, 1'b1, wexp, n0 + 2 + 3*g);
            else            push(1'b0, 1'b0, 1'b1, {24'h0, dexp}, n0 + 2 + 3*g);
        end
        repeat (3*grants) begin @(posedge clk); #1; end
        drop_all();
    endtask

    initial begin
        rstn_i = 1'b0; exec = 1'b0;
        drop_all();
        bus.wb_adr = '0; bus.wb_sel = '0; bus.wb_dat_i = '0;
        bus.dp_addr = '0; bus.dp_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ram_wen", {28'h0, bus.ram_wen}, 32'h0);
        check("rst_ram_a", {23'h0, bus.ram_a}, 32'h0);
        check("rst_ram_wd", bus.ram_wd, 32'h0);
        check("rst_acks", {28'h0, bus.wb_ack, bus.wb_err, bus.dp_ack, bus.dp_err}, 32'h0);
        check("rst_rdata", bus.wb_dat_o | {24'h0, bus.dp_rdata}, 32'h0);
        rstn_i = 1'b1;
        @(posedge clk); #1;

        // DP byte write then read back, host owns buffer
        issue_dp(1'b1, 11'h006, 8'hA5);
        push(1'b0, 1'b0, 1'b0, 32'h0, cyc_cnt + 2);
        @(posedge clk); #1;
        check("dp_wr_wen", {28'h0, bus.ram_wen}, 32'h4);
        check("dp_wr_a", {23'h0, bus.ram_a}, 32'h001);
        check("dp_wr_wd", bus.ram_wd, 32'hA5A5A5A5);
        wait_done("dp_wr");
        issue_dp(1'b0, 11'h006, 8'h00);
        push(1'b0, 1'b0, 1'b1, 32'hA5, cyc_cnt + 2);
        wait_done("dp_rd");

        // CPU partial write and read back
        exec = 1'b1;
        issue_wb(1'b1, 9'h010, 4'b0011, 32'hDEADBEEF);
        push(1'b1, 1'b0, 1'b0, 32'h0, cyc_cnt + 2);
        wait_done("wb_wr");
        check("wb_wr_mem", mem[16], 32'h0000BEEF);
        issue_wb(1'b0, 9'h010, 4'hF, 32'h0);
        push(1'b1, 1'b0, 1'b1, 32'h0000BEEF, cyc_cnt + 2);
        wait_done("wb_rd");

        // rejections
        exec = 1'b0;
        issue_wb(1'b1, 9'h010, 4'hF, 32'h12345678);
        push(1'b1, 1'b1, 1'b1, 32'h0, cyc_cnt + 2);
        @(posedge clk); #1;
        check("wb_rej_wen", {28'h0, bus.ram_wen}, 32'h0);
        wait_done("wb_rej");
        check("wb_rej_mem", mem[16], 32'h0000BEEF);
        exec = 1'b1;
        issue_dp(1'b0, 11'h006, 8'h00);
        push(1'b0, 1'b1, 1'b1, 32'hFF, cyc_cnt + 2);
        wait_done("dp_rej");

        // simultaneous requests held for four grants
        exec = 1'b0;
        tie(4, 9'h010, 32'h0000BEEF, 11'h006, 8'hA5);

        // WB abort in ACC: no response, FSM back in IDLE for a timed DP read
        issue_wb(1'b0, 9'h010, 4'hF, 32'h0);
        @(posedge clk); #1;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        issue_dp(1'b0, 11'h006, 8'h00);
        push(1'b0, 1'b0, 1'b1, 32'hA5, cyc_cnt + 2);
        wait_done("post_abort");

        // exec flipped during ACC keeps grant-time eligibility
        exec = 1'b1;
        issue_wb(1'b1, 9'h011, 4'hF, 32'hCAFEF00D);
        push(1'b1, 1'b0, 1'b0, 32'h0, cyc_cnt + 2);
        @(posedge clk); #1;
        exec = 1'b0;
        wait_done("wb_flip");
        check("wb_flip_mem", mem[17], 32'hCAFEF00D);
        issue_dp(1'b1, 11'h007, 8'h3C);
        push(1'b0, 1'b0, 1'b0, 32'h0, cyc_cnt + 2);
        @(posedge clk); #1;
        exec = 1'b1;
        wait_done("dp_flip");
        check("dp_flip_mem", mem[1], 32'h3CA50000);

        // async reset in ACC of a write
        issue_wb(1'b1, 9'h012, 4'hF, 32'h11111111);
        @(posedge clk); #1;
        check("pre_rst_wen", {28'h0, bus.ram_wen}, 32'hF);
        rstn_i = 1'b0;
        #1;
        check("mid_rst_wen", {28'h0, bus.ram_wen}, 32'h0);
        check("mid_rst_a", {23'h0, bus.ram_a}, 32'h0);
        check("mid_rst_acks", {28'h0, bus.wb_ack, bus.wb_err, bus.dp_ack, bus.dp_err}, 32'h0);
        drop_all();
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        check("rst_mem", mem[18], 32'h0);
        @(posedge clk); #1;
        exec = 1'b0;
        tie(2, 9'h011, 32'hCAFEF00D, 11'h006, 8'hA5);

        repeat (4) @(posedge clk);
        check("wb_q_empty", wb_q.size(), 32'd0);
        check("dp_q_empty", dp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at 200us, required to finish");
        $fatal(1, "timeout");
    end
endmodule
